// File: rtl/if_stage_pkg.sv
// Core-wide constants and field helpers shared by the fetch stage.
package if_stage_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JADDR_MSB = 25;
  localparam int JADDR_LSB = 0;

  // Word-scaled, sign-extended branch displacement from the IMM field.
  function automatic logic [31:0] branch_offset(input logic [31:0] instr);
    return {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_next_pc_calc.sv
// Combinational next-PC selection: sequential, branch target or jump target.
module next_pc_calc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] ifid_pc_plus4_i,
  input  logic [31:0] ifid_instr_i,
  input  logic        take_br_i,
  input  logic        take_j_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] br_target_s;
  logic [31:0] j_target_s;

  assign pc_plus4_o  = pc_i + 32'd4;
  assign br_target_s = ifid_pc_plus4_i + branch_offset(ifid_instr_i);
  assign j_target_s  = {ifid_pc_plus4_i[31:28], ifid_instr_i[JADDR_MSB:JADDR_LSB], 2'b00};

  // Jump wins over branch should the decoder ever raise both.
  always_comb begin
    if (take_j_i) begin
      next_pc_o = j_target_s;
    end else if (take_br_i) begin
      next_pc_o = br_target_s;
    end else begin
      next_pc_o = pc_plus4_o;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and redirect control.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_id,
  input  logic        branch_taken,
  input  logic        jump_id,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        redirect
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        take_br_s, take_j_s, redirect_s;
  logic [31:0] pc_plus4_s, next_pc_s;

  // A bubble in IF/ID can never redirect, which keeps flushed slots inert.
  assign take_br_s  = valid_q & branch_id & branch_taken;
  assign take_j_s   = valid_q & jump_id;
  assign redirect_s = (take_br_s | take_j_s) & ~stall;

  next_pc_calc u_next_pc (
    .pc_i            (pc_q),
    .ifid_pc_plus4_i (pc4_q),
    .ifid_instr_i    (instr_q),
    .take_br_i       (take_br_s),
    .take_j_i        (take_j_s),
    .pc_plus4_o      (pc_plus4_s),
    .next_pc_o       (next_pc_s)
  );

  // Next-state selection: stall holds everything, redirect may insert a bubble.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (stall) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (redirect_s && !DELAY_SLOT) begin
      pc_d    = next_pc_s;
      instr_d = NOP_WORD;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      pc_d    = next_pc_s;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4_s;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pc4_q;
  assign ifid_valid    = valid_q;
  assign redirect      = redirect_s;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench: flush-mode (index 0) and delay-slot-mode (index 1) fetch stages vs a reference model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall[2], branch_id[2], branch_taken[2], jump_id[2];
  logic [31:0] imem_addr[2], imem_rdata[2], ifid_instr[2], ifid_pc_plus4[2];
  logic        ifid_valid[2], redirect[2];

  logic [31:0] salt;
  logic [31:0] ovr_addr[2], ovr_data[2];

  logic [31:0] m_pc[2], m_instr[2], m_pc4[2];
  logic        m_valid[2];

  int vectors, miscompares;
  logic [31:0] saved_pc;

  always #5 clk = ~clk;

  assign imem_rdata[0] = (imem_addr[0] == ovr_addr[0]) ? ovr_data[0] : (imem_addr[0] ^ salt);
  assign imem_rdata[1] = (imem_addr[1] == ovr_addr[1]) ? ovr_data[1] : (imem_addr[1] ^ salt);

  if_stage #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(1'b0)) dut_flush (
    .clk(clk), .rst(rst), .stall(stall[0]), .branch_id(branch_id[0]),
    .branch_taken(branch_taken[0]), .jump_id(jump_id[0]), .imem_addr(imem_addr[0]),
    .imem_rdata(imem_rdata[0]), .ifid_instr(ifid_instr[0]), .ifid_pc_plus4(ifid_pc_plus4[0]),
    .ifid_valid(ifid_valid[0]), .redirect(redirect[0]));

  if_stage #(.RESET_PC(32'hFFFF_FFF0), .DELAY_SLOT(1'b1)) dut_ds (
    .clk(clk), .rst(rst), .stall(stall[1]), .branch_id(branch_id[1]),
    .branch_taken(branch_taken[1]), .jump_id(jump_id[1]), .imem_addr(imem_addr[1]),
    .imem_rdata(imem_rdata[1]), .ifid_instr(ifid_instr[1]), .ifid_pc_plus4(ifid_pc_plus4[1]),
    .ifid_valid(ifid_valid[1]), .redirect(redirect[1]));

  function automatic logic [31:0] mem_rd(int k, logic [31:0] a);
    return (a == ovr_addr[k]) ? ovr_data[k] : (a ^ salt);
  endfunction

  function automatic logic m_redirect(int k);
    return m_valid[k] && (jump_id[k] || (branch_id[k] && branch_taken[k])) && !stall[k];
  endfunction

  task automatic model_reset();
    m_pc[0] = 32'h0000_0000;
    m_pc[1] = 32'hFFFF_FFF0;
    for (int k = 0; k < 2; k++) begin
      m_instr[k] = 32'h0;
      m_pc4[k]   = 32'h0;
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic model_edge(int k);
    logic [31:0] fetched, seq, tgt;
    logic        redir;
    int          off;
    redir   = m_redirect(k);
    fetched = mem_rd(k, m_pc[k]);
    seq     = m_pc[k] + 32'd4;
    off     = $signed(m_instr[k][15:0]);
    if (jump_id[k]) tgt = {m_pc4[k][31:28], m_instr[k][25:0], 2'b00};
    else            tgt = m_pc4[k] + 32'(off * 4);
    if (!stall[k]) begin
      m_pc[k] = redir ? tgt : seq;
      if (redir && k == 0) begin
        m_instr[k] = 32'h0;
        m_pc4[k]   = 32'h0;
        m_valid[k] = 1'b0;
      end else begin
        m_instr[k] = fetched;
        m_pc4[k]   = seq;
        m_valid[k] = 1'b1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_pc%0d", tag, k),    imem_addr[k],         m_pc[k]);
      chk($sformatf("%s_instr%0d", tag, k), ifid_instr[k],        m_instr[k]);
      chk($sformatf("%s_pc4_%0d", tag, k),  ifid_pc_plus4[k],     m_pc4[k]);
      chk($sformatf("%s_valid%0d", tag, k), 32'(ifid_valid[k]),   32'(m_valid[k]));
    end
  endtask

  // One clock: check combinational redirect, advance model at the edge, check registers.
  task automatic cyc();
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("redirect%0d", k), 32'(redirect[k]), 32'(m_redirect(k)));
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    chk_state("cyc");
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    salt = 32'h0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      stall[k] = 1'b0; branch_id[k] = 1'b0; branch_taken[k] = 1'b0; jump_id[k] = 1'b0;
      ovr_addr[k] = 32'h1; ovr_data[k] = 32'h0;
    end
    model_reset();
    #1;
    chk_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch, address-as-data
    cyc(); cyc(); cyc();
    chk("seq_pc", imem_addr[0], 32'h0000_000C);
    chk("seq_instr", ifid_instr[0], 32'h0000_0008);
    chk("seq_valid", 32'(ifid_valid[0]), 32'd1);
    cyc();
    chk("wrap_pc", imem_addr[1], 32'h0000_0000);
    chk("wrap_pc4", ifid_pc_plus4[1], 32'h0000_0000);

    // Jump to 0x100 then forward taken branch imm=3 from 0x100
    ovr_addr[0] = 32'h10; ovr_data[0] = 32'h0800_0040;
    cyc();
    jump_id[0] = 1'b1;
    cyc();
    chk("jmp_pc", imem_addr[0], 32'h0000_0100);
    chk("jmp_bubble", 32'(ifid_valid[0]), 32'd0);
    jump_id[0] = 1'b0;
    ovr_addr[0] = 32'h100; ovr_data[0] = 32'h1000_0003;
    cyc();
    chk("br_pc4", ifid_pc_plus4[0], 32'h0000_0104);
    branch_id[0] = 1'b1; branch_taken[0] = 1'b1;
    ovr_addr[0] = 32'h110; ovr_data[0] = 32'h1000_FFFE;
    cyc();
    chk("br_fwd_pc", imem_addr[0], 32'h0000_0110);
    chk("br_bubble", 32'(ifid_valid[0]), 32'd0);
    cyc();
    chk("bubble_no_redirect_pc", imem_addr[0], 32'h0000_0114);
    cyc();
    chk("br_back_pc", imem_addr[0], 32'h0000_010C);
    ovr_addr[0] = 32'h10C;
    cyc();
    branch_taken[0] = 1'b0;
    cyc();
    chk("nt_pc", imem_addr[0], 32'h0000_0114);
    chk("nt_valid", 32'(ifid_valid[0]), 32'd1);
    branch_id[0] = 1'b0;

    // Delay-slot mode: jump into 0x0FFF_FFFC, then j 0x100 from 0x1000_0004
    ovr_addr[1] = m_pc[1]; ovr_data[1] = 32'h0BFF_FFFF;
    cyc();
    jump_id[1] = 1'b1;
    cyc();
    chk("ds_j1_pc", imem_addr[1], 32'h0FFF_FFFC);
    chk("ds_j1_valid", 32'(ifid_valid[1]), 32'd1);
    jump_id[1] = 1'b0;
    cyc();
    ovr_addr[1] = 32'h1000_0004; ovr_data[1] = 32'h0800_0040;
    cyc(); cyc();
    chk("ds_pc4", ifid_pc_plus4[1], 32'h1000_0008);
    jump_id[1] = 1'b1;
    cyc();
    chk("ds_j2_pc", imem_addr[1], 32'h1000_0100);
    chk("ds_slot_instr", ifid_instr[1], 32'h1000_0008);
    chk("ds_slot_valid", 32'(ifid_valid[1]), 32'd1);
    chk("ds_slot_pc4", ifid_pc_plus4[1], 32'h1000_000C);
    jump_id[1] = 1'b0;

    // Stall with taken branch in ID, then release
    ovr_addr[0] = m_pc[0]; ovr_data[0] = 32'h1000_0005;
    cyc();
    saved_pc = m_pc[0];
    branch_id[0] = 1'b1; branch_taken[0] = 1'b1; stall[0] = 1'b1;
    repeat (3) cyc();
    chk("stall_pc", imem_addr[0], saved_pc);
    stall[0] = 1'b0;
    cyc();
    chk("stall_release_pc", imem_addr[0], saved_pc + 32'd20);
    branch_id[0] = 1'b0; branch_taken[0] = 1'b0;

    // Asynchronous reset during a redirect
    ovr_addr[0] = m_pc[0]; ovr_data[0] = 32'h1000_0002;
    cyc();
    branch_id[0] = 1'b1; branch_taken[0] = 1'b1;
    #1;
    chk("pre_rst_redirect", 32'(redirect[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc0", imem_addr[0], 32'h0000_0000);
    chk("arst_valid0", 32'(ifid_valid[0]), 32'd0);
    chk("arst_redirect0", 32'(redirect[0]), 32'd0);
    chk("arst_pc1", imem_addr[1], 32'hFFFF_FFF0);
    chk("arst_valid1", 32'(ifid_valid[1]), 32'd0);
    model_reset();
    branch_id[0] = 1'b0; branch_taken[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Randomized control traffic over pseudo-random instruction words
    salt = $urandom;
    ovr_addr[0] = 32'h1; ovr_addr[1] = 32'h1;
    repeat (400) begin
      for (int k = 0; k < 2; k++) begin
        int r;
        r = $urandom_range(0, 9);
        branch_id[k]    = (r <= 3);
        branch_taken[k] = (r <= 2);
        jump_id[k]      = (r == 4) || (r == 5);
        stall[k]        = ($urandom_range(0, 3) == 0);
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
- Holds the PC, drives the instruction-memory address, and latches the fetched instruction plus PC+4 into IF/ID.
- Consumes the ID-stage branch decision from the branch comparator and the jump decode, and redirects fetch.
- Squashes the wrong-path instruction unless delay-slot mode is enabled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DELAY_SLOT, 0, 1 = instruction in IF at redirect is kept (MIPS delay slot); 0 = it is flushed to NOP

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID this cycle
branch_id  in  1  instruction in ID is a beq (decoded)
branch_taken  in  1  comparator result for the ID instruction (r1 == r2)
jump_id  in  1  instruction in ID is j
imem_addr  out  32  instruction memory address (= pc)
imem_rdata  in  32  instruction word, combinational read of imem_addr
ifid_instr  out  32  IF/ID instruction register
ifid_pc_plus4  out  32  IF/ID PC+4 register
ifid_valid  out  1  IF/ID holds a real instruction
redirect  out  1  combinational: redirect occurring this cycle (to hazard/debug)

Behaviour:
Reset (async, any time, including mid-redirect):
- pc = RESET_PC.
- ifid_instr = 32'h0000_0000 (NOP).
- ifid_pc_plus4 = 0.
- ifid_valid = 0.
- First fetch occurs in the first clock edge after rst deasserts.

Address and arithmetic:
- imem_addr = pc at all times.
- pc_plus4 = pc + 4, modulo 2^32; wraps from 32'hFFFF_FFFC to 0.
- Branch target = ifid_pc_plus4 + (sign_extend(ifid_instr[15:0]) << 2), 32-bit, wraps.
- Jump target = {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}.
- pc[1:0] is always 00 by construction.

Redirect decode (combinational, from the current IF/ID contents):
- take_br = ifid_valid & branch_id & branch_taken.
- take_j = ifid_valid & jump_id.
- redirect = (take_br | take_j) & ~stall.
- take_j has priority if both are asserted; the decoder must never assert both.

Per-edge update, priority order:
1. stall = 1: pc and all IF/ID registers hold. A branch resolving while stalled is ignored; it is re-evaluated in the next unstalled cycle because IF/ID still holds it.
2. redirect = 1:
   - pc <= target.
   - DELAY_SLOT = 0: ifid_instr <= 0, ifid_pc_plus4 <= 0, ifid_valid <= 0 (one bubble).
   - DELAY_SLOT = 1: ifid_instr <= imem_rdata, ifid_pc_plus4 <= pc_plus4, ifid_valid <= 1.
3. Otherwise: pc <= pc_plus4, ifid_instr <= imem_rdata, ifid_pc_plus4 <= pc_plus4, ifid_valid <= 1.

Timing and special cases:
- Branch/jump penalty: 1 cycle (flush mode) or 0 lost slots (delay-slot mode).
- Latency: an instruction at address A appears in ifid_instr one edge after pc == A.
- A branch whose target is its own address is legal and loops.
- ifid_valid = 0 suppresses redirect, so a flushed bubble can never redirect.
- Not-taken branch (branch_id = 1, branch_taken = 0): sequential fetch, no flush.

Decomposition:
Shared package (core-wide):
- NOP word 32'h0000_0000.
- Instruction field ranges: IMM = [15:0], JADDR = [25:0].
- RESET_PC default.

Sub-module: next_pc_calc.
- Pure combinational.
- Inputs: pc, ifid_pc_plus4, ifid_instr, take_br, take_j.
- Outputs: pc_plus4, next_pc.
- Keeps the target arithmetic separately testable.
- The if_stage top holds all registers and the stall/flush priority logic.

Test Plan:
1. Reset and sequential fetch: rst high 2 cycles, RESET_PC = 0, imem returns address-as-data -> pc 0, 4, 8, C on successive edges; ifid_instr lags pc by one cycle, ifid_valid = 1 from the second edge.
2. Taken branch, flush mode: ifid_pc_plus4 = 0x104, imm = 16'h0003, branch_id = 1, branch_taken = 1 -> next pc = 0x110, ifid_valid = 0 for one cycle, redirect = 1 for that cycle only.
3. Backward branch and not-taken: imm = 16'hFFFE, ifid_pc_plus4 = 0x104 -> pc = 0xFC; same instruction with branch_taken = 0 -> pc = pc + 4, no bubble.
4. Jump and delay slot: DELAY_SLOT = 1, ifid_pc_plus4 = 0x1000_0008, instr[25:0] = 26'h40 -> pc = 0x1000_0100, and the instruction at 0x1000_0008 enters IF/ID with ifid_valid = 1.
5. Stall interactions: stall = 1 for 3 cycles with a taken branch in ID -> pc and IF/ID frozen, redirect = 0; stall drops -> redirect taken on that edge.
6. Wrap and async reset: pc = 0xFFFF_FFFC -> next pc = 0; assert rst asynchronously mid-cycle during a redirect -> pc = RESET_PC and ifid_valid = 0 immediately, without waiting for a clock edge.
